// File: rtl/sd_sector_client_pkg.sv
// Shared types and constants for the SD image sector client.
package sd_sector_client_pkg;

   localparam int unsigned SD_SECTOR_BYTES = 512;

   typedef enum logic [2:0] {
      SDC_IDLE,
      SDC_REQ,
      SDC_XFER,
      SDC_DONE,
      SDC_ERR
   } sd_client_state_t;

endpackage

// File: rtl/sd_sector_buffer.sv
// True dual-port BLK_BYTES x 8 sector RAM with registered reads on both ports.
module sd_sector_buffer
   import sd_sector_client_pkg::*;
#(
   parameter int unsigned BLK_BYTES = SD_SECTOR_BYTES,
   localparam int unsigned AW = $clog2(BLK_BYTES)
) (
   input  logic          i_clk,
   input  logic [AW-1:0] i_a_addr,
   input  logic [7:0]    i_a_wdata,
   input  logic          i_a_we,
   output logic [7:0]    o_a_rdata,
   input  logic [AW-1:0] i_b_addr,
   input  logic [7:0]    i_b_wdata,
   input  logic          i_b_we,
   output logic [7:0]    o_b_rdata
);

   logic [7:0] r_mem [BLK_BYTES];
   logic [7:0] r_a_rdata;
   logic [7:0] r_b_rdata;

   // Port B is written last so an SD write wins a same-address collision.
   always_ff @(posedge i_clk) begin
      if (i_a_we) begin
         r_mem[i_a_addr] <= i_a_wdata;
      end
      if (i_b_we) begin
         r_mem[i_b_addr] <= i_b_wdata;
      end
      r_a_rdata <= r_mem[i_a_addr];
      r_b_rdata <= r_mem[i_b_addr];
   end

   assign o_a_rdata = r_a_rdata;
   assign o_b_rdata = r_b_rdata;

endmodule

// File: rtl/sd_sector_client.sv
// SD image sector client: one sector read/write per request through a local buffer,
// with a request/done handshake toward the disk logic.
module sd_sector_client
   import sd_sector_client_pkg::*;
#(
   parameter int unsigned BLK_BYTES   = SD_SECTOR_BYTES,
   parameter logic [23:0] ACK_TIMEOUT = 24'd10_000_000,
   localparam int unsigned AW = $clog2(BLK_BYTES)
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_req_valid,
   output logic          o_req_ready,
   input  logic          i_req_write,
   input  logic [31:0]   i_req_lba,
   output logic          o_done,
   output logic          o_err,
   input  logic [AW-1:0] i_usr_addr,
   input  logic [7:0]    i_usr_wdata,
   input  logic          i_usr_we,
   output logic [7:0]    o_usr_rdata,
   input  logic          i_img_mounted,
   input  logic          i_img_readonly,
   input  logic [31:0]   i_img_size,
   output logic          o_sd_rd,
   output logic          o_sd_wr,
   output logic [31:0]   o_sd_lba,
   output logic [7:0]    o_sd_buff_din,
   input  logic          i_sd_ack,
   input  logic [13:0]   i_sd_buff_addr,
   input  logic [7:0]    i_sd_buff_dout,
   input  logic          i_sd_buff_wr
);

   sd_client_state_t r_state, w_state_next;
   logic        r_write,   w_write_next;
   logic        r_sd_rd,   w_sd_rd_next;
   logic        r_sd_wr,   w_sd_wr_next;
   logic [31:0] r_sd_lba,  w_sd_lba_next;
   logic [23:0] r_tmo,     w_tmo_next;
   logic        r_ack_low, w_ack_low_next;
   logic        r_rd_valid;
   logic [31:0] w_sectors;
   logic        w_b_we;
   logic [7:0]  w_a_rdata;
   logic [7:0]  w_b_rdata;

   assign w_sectors = i_img_size >> AW;
   assign w_b_we    = (r_state == SDC_XFER) && !r_write && i_sd_buff_wr;

   always_comb begin
      w_state_next   = r_state;
      w_write_next   = r_write;
      w_sd_rd_next   = r_sd_rd;
      w_sd_wr_next   = r_sd_wr;
      w_sd_lba_next  = r_sd_lba;
      w_tmo_next     = r_tmo;
      w_ack_low_next = r_ack_low;
      unique case (r_state)
         SDC_IDLE: begin
            if (i_req_valid) begin
               w_write_next = i_req_write;
               if (!i_img_mounted || (i_req_write && i_img_readonly) ||
                   (i_req_lba >= w_sectors)) begin
                  w_state_next = SDC_ERR;
               end else begin
                  w_sd_lba_next  = i_req_lba;
                  w_sd_rd_next   = !i_req_write;
                  w_sd_wr_next   = i_req_write;
                  w_tmo_next     = '0;
                  // An ack already high here is stale and must drop before it counts.
                  w_ack_low_next = !i_sd_ack;
                  w_state_next   = SDC_REQ;
               end
            end
         end
         SDC_REQ: begin
            if (!i_sd_ack) begin
               w_ack_low_next = 1'b1;
            end
            if (!i_img_mounted) begin
               w_sd_rd_next = 1'b0;
               w_sd_wr_next = 1'b0;
               w_state_next = SDC_ERR;
            end else if (i_sd_ack && r_ack_low) begin
               w_sd_rd_next = 1'b0;
               w_sd_wr_next = 1'b0;
               w_state_next = SDC_XFER;
            end else if (r_tmo == ACK_TIMEOUT - 24'd1) begin
               w_sd_rd_next = 1'b0;
               w_sd_wr_next = 1'b0;
               w_state_next = SDC_ERR;
            end else begin
               w_tmo_next = r_tmo + 24'd1;
            end
         end
         SDC_XFER: begin
            if (!i_sd_ack) begin
               w_state_next = SDC_DONE;
            end
         end
         SDC_DONE: w_state_next = SDC_IDLE;
         SDC_ERR:  w_state_next = SDC_IDLE;
         default:  w_state_next = SDC_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state    <= SDC_IDLE;
         r_write    <= 1'b0;
         r_sd_rd    <= 1'b0;
         r_sd_wr    <= 1'b0;
         r_sd_lba   <= '0;
         r_tmo      <= '0;
         r_ack_low  <= 1'b0;
         r_rd_valid <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_write    <= w_write_next;
         r_sd_rd    <= w_sd_rd_next;
         r_sd_wr    <= w_sd_wr_next;
         r_sd_lba   <= w_sd_lba_next;
         r_tmo      <= w_tmo_next;
         r_ack_low  <= w_ack_low_next;
         r_rd_valid <= 1'b1;
      end
   end

   sd_sector_buffer #(
      .BLK_BYTES (BLK_BYTES)
   ) u_buffer (
      .i_clk     (i_clk),
      .i_a_addr  (i_usr_addr),
      .i_a_wdata (i_usr_wdata),
      .i_a_we    (i_usr_we),
      .o_a_rdata (w_a_rdata),
      .i_b_addr  (i_sd_buff_addr[AW-1:0]),
      .i_b_wdata (i_sd_buff_dout),
      .i_b_we    (w_b_we),
      .o_b_rdata (w_b_rdata)
   );

   generate
      if (AW < 14) begin : g_addr_hi
         logic w_unused_addr_hi;
         assign w_unused_addr_hi = ^i_sd_buff_addr[13:AW];
      end
   endgenerate

   // RAM read registers carry no reset; mask them until one clean read has completed.
   assign o_usr_rdata   = r_rd_valid ? w_a_rdata : 8'h00;
   assign o_sd_buff_din = r_rd_valid ? w_b_rdata : 8'h00;
   assign o_req_ready   = (r_state == SDC_IDLE);
   assign o_done        = (r_state == SDC_DONE) || (r_state == SDC_ERR);
   assign o_err         = (r_state == SDC_ERR);
   assign o_sd_rd       = r_sd_rd;
   assign o_sd_wr       = r_sd_wr;
   assign o_sd_lba      = r_sd_lba;

endmodule

// File: tb/tb_sd_sector_client.sv
// Randomised self-checking bench for sd_sector_client against a byte-array buffer model.
module tb_sd_sector_client;

   localparam int          BLK = 512;
   localparam logic [23:0] TMO = 24'd100;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_lba;
   logic        done, err;
   logic [8:0]  usr_addr;
   logic [7:0]  usr_wdata, usr_rdata;
   logic        usr_we;
   logic        img_mounted, img_readonly;
   logic [31:0] img_size;
   logic        sd_rd, sd_wr;
   logic [31:0] sd_lba;
   logic [7:0]  sd_buff_din, sd_buff_dout;
   logic        sd_ack, sd_buff_wr;
   logic [13:0] sd_buff_addr;

   logic [7:0]  ref_buf [BLK];
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   sd_sector_client #(
      .BLK_BYTES   (BLK),
      .ACK_TIMEOUT (TMO)
   ) dut (
      .i_clk          (clk),
      .i_reset        (reset),
      .i_req_valid    (req_valid),
      .o_req_ready    (req_ready),
      .i_req_write    (req_write),
      .i_req_lba      (req_lba),
      .o_done         (done),
      .o_err          (err),
      .i_usr_addr     (usr_addr),
      .i_usr_wdata    (usr_wdata),
      .i_usr_we       (usr_we),
      .o_usr_rdata    (usr_rdata),
      .i_img_mounted  (img_mounted),
      .i_img_readonly (img_readonly),
      .i_img_size     (img_size),
      .o_sd_rd        (sd_rd),
      .o_sd_wr        (sd_wr),
      .o_sd_lba       (sd_lba),
      .o_sd_buff_din  (sd_buff_din),
      .i_sd_ack       (sd_ack),
      .i_sd_buff_addr (sd_buff_addr),
      .i_sd_buff_dout (sd_buff_dout),
      .i_sd_buff_wr   (sd_buff_wr)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic bit exp_reject(input bit w, input logic [31:0] lba);
      logic [31:0] sectors;
      sectors = img_size / BLK;
      return !img_mounted || (w && img_readonly) || (lba >= sectors);
   endfunction

   task automatic wait_ready();
      int k = 0;
      while (!req_ready && k < 50) begin
         cyc();
         k++;
      end
      check_eq("ready_wait", 32'(req_ready), 32'd1);
   endtask

   task automatic issue(input bit w, input logic [31:0] lba);
      req_valid = 1'b1;
      req_write = w;
      req_lba   = lba;
      cyc();
      req_valid = 1'b0;
      req_lba   = $urandom;
   endtask

   task automatic finish_ok(input string tag);
      sd_buff_wr = 1'b0;
      sd_ack     = 1'b0;
      cyc();
      check_eq({tag, "_done"}, {done, err}, 2'b10);
      cyc();
      check_eq({tag, "_idle"}, {req_ready, done}, 2'b10);
   endtask

   task automatic do_read(input logic [31:0] lba, input int nbytes, input int dly, input bit pat);
      int a;
      logic [7:0] d;
      wait_ready();
      issue(1'b0, lba);
      check_eq("rd_req", {sd_rd, sd_wr}, 2'b10);
      check_eq("rd_lba", sd_lba, lba);
      repeat (dly) cyc();
      check_eq("rd_hold", 32'(sd_rd), 32'd1);
      sd_ack = 1'b1;
      cyc();
      check_eq("rd_drop", 32'(sd_rd), 32'd0);
      for (int i = 0; i < nbytes; i++) begin
         if (!pat && $urandom_range(0, 3) == 0) begin
            sd_buff_wr   = 1'b0;
            sd_buff_dout = 8'($urandom);
            cyc();
         end
         a = pat ? i : int'($urandom_range(0, 16383));
         d = pat ? 8'(i ^ 'hA5) : 8'($urandom);
         sd_buff_addr = 14'(a);
         sd_buff_dout = d;
         sd_buff_wr   = 1'b1;
         cyc();
         ref_buf[a % BLK] = d;
      end
      finish_ok("rd");
   endtask

   task automatic do_write(input logic [31:0] lba, input int dly);
      wait_ready();
      issue(1'b1, lba);
      check_eq("wr_req", {sd_rd, sd_wr}, 2'b01);
      check_eq("wr_lba", sd_lba, lba);
      repeat (dly) cyc();
      sd_ack = 1'b1;
      cyc();
      check_eq("wr_drop", 32'(sd_wr), 32'd0);
      for (int i = 0; i < BLK; i++) begin
         // Upper address bits and stray strobes must not matter on a write.
         sd_buff_addr = 14'(i + ($urandom_range(0, 31) * BLK));
         sd_buff_dout = 8'($urandom);
         sd_buff_wr   = 1'b1;
         cyc();
         check_eq("wr_byte", 32'(sd_buff_din), 32'(ref_buf[i]));
      end
      finish_ok("wr");
   endtask

   task automatic do_reject(input bit w, input logic [31:0] lba);
      wait_ready();
      issue(w, lba);
      check_eq("rej_done", {done, err}, 2'b11);
      check_eq("rej_nosd", {sd_rd, sd_wr}, 2'b00);
      cyc();
      check_eq("rej_idle", {req_ready, done, sd_rd, sd_wr}, 4'b1000);
   endtask

   task automatic user_fill(input bit seq);
      for (int i = 0; i < BLK; i++) begin
         usr_addr  = 9'(i);
         usr_wdata = seq ? 8'(i) : 8'($urandom);
         usr_we    = 1'b1;
         cyc();
         ref_buf[i] = usr_wdata;
      end
      usr_we = 1'b0;
   endtask

   task automatic user_verify();
      for (int i = 0; i < BLK; i++) begin
         usr_addr = 9'(i);
         cyc();
         check_eq("usr_rd", 32'(usr_rdata), 32'(ref_buf[i]));
      end
   endtask

   initial begin
      int k;
      bit w;
      logic [31:0] lba;
      reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_lba = '0;
      usr_addr = '0; usr_wdata = '0; usr_we = 1'b0;
      img_mounted = 1'b1; img_readonly = 1'b0; img_size = 32'h0010_0000;
      sd_ack = 1'b0; sd_buff_addr = '0; sd_buff_dout = '0; sd_buff_wr = 1'b0;
      for (int i = 0; i < BLK; i++) ref_buf[i] = 8'h00;
      repeat (3) cyc();
      check_eq("rst_ctl", {req_ready, done, err, sd_rd, sd_wr}, 5'b10000);
      check_eq("rst_lba", sd_lba, 32'd0);
      check_eq("rst_data", {sd_buff_din, usr_rdata}, 16'h0000);
      reset = 1'b1;
      cyc();
      // Directed read, write, range, permission and timeout scenarios.
      do_read(32'd5, BLK, 20, 1'b1);
      usr_addr = 9'h1FF;
      cyc();
      check_eq("usr_1ff", 32'(usr_rdata), 32'h5A);
      user_fill(1'b1);
      do_write(32'd7, 5);
      img_size = 32'h2000;
      do_reject(1'b0, 32'd16);
      do_read(32'd15, int'($urandom_range(1, 300)), 3, 1'b0);
      user_verify();
      img_readonly = 1'b1;
      do_reject(1'b1, 32'd3);
      img_readonly = 1'b0;
      img_mounted = 1'b0;
      do_reject(1'b0, 32'd3);
      img_mounted = 1'b1;
      wait_ready();
      issue(1'b0, 32'd2);
      check_eq("tmo_rd", 32'(sd_rd), 32'd1);
      k = 0;
      do begin
         cyc();
         k++;
      end while (!done && k < 150);
      check_eq("tmo_cycles", k, 100);
      check_eq("tmo_err", {err, sd_rd}, 2'b10);
      // Stale ack must drop before a new rising edge is accepted.
      sd_ack = 1'b1;
      wait_ready();
      issue(1'b0, 32'd1);
      repeat (4) cyc();
      check_eq("stale_hold", 32'(sd_rd), 32'd1);
      sd_ack = 1'b0;
      cyc();
      sd_ack = 1'b1;
      cyc();
      check_eq("stale_drop", 32'(sd_rd), 32'd0);
      finish_ok("stale");
      wait_ready();
      issue(1'b0, 32'd1);
      img_mounted = 1'b0;
      cyc();
      check_eq("unmount_req", {done, err, sd_rd}, 3'b110);
      img_mounted = 1'b1;
      cyc();
      // Random mix of accepted and rejected requests.
      for (int n = 0; n < 20; n++) begin
         img_size     = 32'($urandom_range(1, 64) * BLK + $urandom_range(0, BLK - 1));
         img_mounted  = ($urandom_range(0, 7) != 0);
         img_readonly = ($urandom_range(0, 3) == 0);
         w            = 1'($urandom_range(0, 1));
         lba          = 32'($urandom_range(0, img_size / BLK + 2));
         if ($urandom_range(0, 3) == 0) user_fill(1'b0);
         if (exp_reject(w, lba)) do_reject(w, lba);
         else if (w) do_write(lba, int'($urandom_range(0, 10)));
         else do_read(lba, int'($urandom_range(0, 600)), int'($urandom_range(0, 10)), 1'b0);
      end
      user_verify();
      // Reset in the middle of a read transfer.
      img_mounted = 1'b1; img_readonly = 1'b0; img_size = 32'h0010_0000;
      wait_ready();
      issue(1'b0, 32'd9);
      sd_ack = 1'b1;
      cyc();
      for (int i = 0; i < 200; i++) begin
         sd_buff_addr = 14'(i);
         sd_buff_dout = 8'($urandom);
         sd_buff_wr   = 1'b1;
         cyc();
         ref_buf[i] = sd_buff_dout;
      end
      sd_buff_wr = 1'b0;
      reset = 1'b0;
      cyc();
      check_eq("rstx_ctl", {req_ready, done, err, sd_rd, sd_wr}, 5'b10000);
      check_eq("rstx_lba", sd_lba, 32'd0);
      check_eq("rstx_data", {sd_buff_din, usr_rdata}, 16'h0000);
      reset = 1'b1;
      for (int i = 200; i < BLK; i++) begin
         sd_buff_addr = 14'(i);
         sd_buff_dout = 8'($urandom);
         sd_buff_wr   = 1'b1;
         cyc();
      end
      sd_buff_wr = 1'b0;
      sd_ack = 1'b0;
      cyc();
      check_eq("rstx_quiet", {req_ready, done}, 2'b10);
      user_verify();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
